tcb_arbiter: RTL and testbench

Round-robin arbiter that shares one TCB subordinate port between MAN_N TCB manager ports. It forwards the granted manager's request and routes the subordinate's response back to the issuing manager, DLY cycles after the transfer. It sits between several bus managers (e.g. instruction fetch, load/store, debug) and a single memory or peripheral subordinate.

---
 rtl/tcb_arbiter_if.sv | 27 ++
 rtl/tcb_arbiter.sv | 96 +++++++++
 tb/tb_tcb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tcb_arbiter_if.sv
// Signal bundle between the TCB managers, the round-robin arbiter and the shared subordinate.
// The arbiter takes the slave modport; the environment driving both sides takes master.
interface tcb_arbiter_if #(
    parameter int unsigned MAN_N = 2,
    parameter int unsigned REQ_W = 72,
    parameter int unsigned RSP_W = 40
);
    logic [MAN_N-1:0]       man_vld;
    logic [MAN_N-1:0]       man_rdy;
    logic [MAN_N*REQ_W-1:0] man_req;
    logic [RSP_W-1:0]       man_rsp;
    logic [MAN_N-1:0]       man_rsp_vld;
    logic                   sub_vld;
    logic                   sub_rdy;
    logic [REQ_W-1:0]       sub_req;
    logic [RSP_W-1:0]       sub_rsp;

    modport slave (
        input  man_vld, man_req, sub_rdy, sub_rsp,
        output man_rdy, man_rsp, man_rsp_vld, sub_vld, sub_req
    );

    modport master (
        output man_vld, man_req, sub_rdy, sub_rsp,
        input  man_rdy, man_rsp, man_rsp_vld, sub_vld, sub_req
    );
endinterface

// File: rtl/tcb_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between MAN_N managers; responses are
// steered back to the issuing manager through a DLY-stage index delay line.
module tcb_arbiter #(
    parameter int unsigned MAN_N = 2,
    parameter int unsigned DLY   = 1,
    parameter int unsigned REQ_W = 72,
    parameter int unsigned RSP_W = 40
) (
    input  logic          clk,
    input  logic          rst,
    tcb_arbiter_if.slave  bus_io
);
    localparam int unsigned IDX_W = (MAN_N > 1) ? $clog2(MAN_N) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_q, gnt;
    logic             lck_q, lck_d;
    logic             sub_vld;
    logic             trn;
    logic             rsp_trn;
    logic [IDX_W-1:0] rsp_idx;
    logic [IDX_W-1:0] cand;
    int               j;
    logic [REQ_W-1:0] req_arr [MAN_N];

    // Descending scan so the lowest offset from ptr_q is assigned last and wins.
    always_comb begin
        gnt  = ptr_q;
        j    = 0;
        cand = '0;
        if (lck_q) begin
            gnt = gnt_q;
        end else begin
            for (int k = int'(MAN_N) - 1; k >= 0; k--) begin
                j    = (int'(ptr_q) + k) % int'(MAN_N);
                cand = IDX_W'(j);
                if (bus_io.man_vld[cand]) gnt = cand;
            end
        end
    end

    for (genvar i = 0; i < int'(MAN_N); i++) begin : g_man
        assign req_arr[i]            = bus_io.man_req[i*REQ_W +: REQ_W];
        assign bus_io.man_rdy[i]     = bus_io.sub_rdy && (gnt == IDX_W'(i));
        assign bus_io.man_rsp_vld[i] = rsp_trn && (rsp_idx == IDX_W'(i));
    end

    assign sub_vld        = bus_io.man_vld[gnt];
    assign bus_io.sub_vld = sub_vld;
    assign bus_io.sub_req = req_arr[gnt];
    assign bus_io.man_rsp = bus_io.sub_rsp;
    assign trn            = sub_vld && bus_io.sub_rdy;

    always_comb begin
        ptr_d = ptr_q;
        lck_d = sub_vld && !bus_io.sub_rdy;
        if (trn) ptr_d = (gnt == IDX_W'(MAN_N - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            lck_q <= 1'b0;
            gnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            lck_q <= lck_d;
            gnt_q <= gnt;
        end
    end

    if (DLY > 0) begin : g_dly
        logic [DLY-1:0]   trn_q;
        logic [IDX_W-1:0] idx_q [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                trn_q <= '0;
                for (int k = 0; k < int'(DLY); k++) idx_q[k] <= '0;
            end else begin
                trn_q[0] <= trn;
                idx_q[0] <= gnt;
                for (int k = 1; k < int'(DLY); k++) begin
                    trn_q[k] <= trn_q[k-1];
                    idx_q[k] <= idx_q[k-1];
                end
            end
        end

        assign rsp_trn = trn_q[DLY-1];
        assign rsp_idx = idx_q[DLY-1];
    end else begin : g_no_dly
        assign rsp_trn = trn;
        assign rsp_idx = gnt;
    end
endmodule

// File: tb/tb_tcb_arbiter.sv
// Bench for tcb_arbiter: DLY=1 and DLY=2 instances share stimulus and are checked against
// a transfer-log reference model.
module tb_tcb_arbiter;
    localparam int unsigned N     = 2;
    localparam int unsigned REQ_W = 72;
    localparam int unsigned RSP_W = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       man_vld = '0;
    logic [N*REQ_W-1:0] man_req = '0;
    logic               sub_rdy = 1'b0;
    logic [RSP_W-1:0]   sub_rsp = '0;

    tcb_arbiter_if #(.MAN_N(N), .REQ_W(REQ_W), .RSP_W(RSP_W)) bus1 ();
    tcb_arbiter_if #(.MAN_N(N), .REQ_W(REQ_W), .RSP_W(RSP_W)) bus2 ();

    assign bus1.man_vld = man_vld;
    assign bus1.man_req = man_req;
    assign bus1.sub_rdy = sub_rdy;
    assign bus1.sub_rsp = sub_rsp;
    assign bus2.man_vld = man_vld;
    assign bus2.man_req = man_req;
    assign bus2.sub_rdy = sub_rdy;
    assign bus2.sub_rsp = sub_rsp;

    tcb_arbiter #(.MAN_N(N), .DLY(1), .REQ_W(REQ_W), .RSP_W(RSP_W)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus1)
    );
    tcb_arbiter #(.MAN_N(N), .DLY(2), .REQ_W(REQ_W), .RSP_W(RSP_W)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus2)
    );

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int rst_cyc = 0;

    // Reference state: round-robin start, lock flag, locked index, per-cycle transfer log.
    int m_ptr = 0;
    bit m_lck = 1'b0;
    int m_gq  = 0;
    bit log_trn [4096];
    int log_idx [4096];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Nearest requester at or after the pointer, measured as circular distance.
    function automatic int rr_pick(input logic [N-1:0] vld, input int ptr);
        int best  = ptr;
        int bestd = int'(N);
        for (int i = 0; i < int'(N); i++) begin
            int d = (i - ptr + int'(N)) % int'(N);
            if (vld[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_rsp(input int d);
        if (cyc - d >= rst_cyc && log_trn[cyc-d]) return N'(1) << log_idx[cyc-d];
        return '0;
    endfunction

    // Entered just after a negedge with inputs applied; leaves at the next negedge.
    task automatic run_cycle();
        int               g;
        logic             e_vld;
        logic [REQ_W-1:0] e_req;
        logic [N-1:0]     e_rdy;
        logic             trn;
        #1;
        g     = m_lck ? m_gq : rr_pick(man_vld, m_ptr);
        e_vld = man_vld[g];
        e_req = man_req[g*REQ_W +: REQ_W];
        e_rdy = sub_rdy ? (N'(1) << g) : '0;
        trn   = e_vld && sub_rdy;
        log_trn[cyc] = trn;
        log_idx[cyc] = g;
        check("sub_vld_d1", bus1.sub_vld, e_vld);
        check("sub_vld_d2", bus2.sub_vld, e_vld);
        check("sub_req_d1", bus1.sub_req, e_req);
        check("sub_req_d2", bus2.sub_req, e_req);
        check("man_rdy_d1", bus1.man_rdy, e_rdy);
        check("man_rdy_d2", bus2.man_rdy, e_rdy);
        check("rsp_vld_d1", bus1.man_rsp_vld, exp_rsp(1));
        check("rsp_vld_d2", bus2.man_rsp_vld, exp_rsp(2));
        check("man_rsp_d1", bus1.man_rsp, sub_rsp);
        check("man_rsp_d2", bus2.man_rsp, sub_rsp);
        @(posedge clk);
        if (trn) m_ptr = (g + 1) % int'(N);
        m_lck = e_vld && !sub_rdy;
        m_gq  = g;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic rdy);
        man_vld = vld;
        sub_rdy = rdy;
        sub_rsp = RSP_W'({$urandom(), $urandom()});
        man_req = (N*REQ_W)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        run_cycle();
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_vld_d1", bus1.man_rsp_vld, '0);
        check("rst_rsp_vld_d2", bus2.man_rsp_vld, '0);
        check("rst_sub_vld", bus1.sub_vld, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Single request with a recognisable payload.
        man_vld = 2'b01;
        sub_rdy = 1'b1;
        man_req = {72'h0, 72'hAA_5555_1234_ABCD_0001};
        sub_rsp = 40'h12_3456_789A;
        run_cycle();
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b1);

        // Round-robin under full load.
        repeat (4) drive(2'b11, 1'b1);
        // Stall lock, then release.
        repeat (3) drive(2'b11, 1'b0);
        repeat (2) drive(2'b11, 1'b1);
        // Idle gap.
        repeat (3) drive(2'b00, 1'b1);
        // Back-to-back 0,1,1 for the DLY=2 pipeline.
        drive(2'b01, 1'b1);
        drive(2'b10, 1'b1);
        drive(2'b10, 1'b1);
        repeat (3) drive(2'b00, 1'b1);

        // Randomized traffic, including locked managers dropping valid.
        repeat (400) drive(N'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));

        // Async reset with transfers in flight; leaves ptr at 1 before reset.
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b1);
        drive(2'b01, 1'b1);
        man_vld = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rsp_d1", bus1.man_rsp_vld, '0);
        check("mid_rst_rsp_d2", bus2.man_rsp_vld, '0);
        check("mid_rst_sub_vld", bus2.sub_vld, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        check("held_rst_rsp_d2", bus2.man_rsp_vld, '0);
        @(negedge clk);
        rst     = 1'b1;
        m_ptr   = 0;
        m_lck   = 1'b0;
        m_gq    = 0;
        cyc     = cyc + 2;
        rst_cyc = cyc;
        repeat (3) drive(2'b00, 1'b1);
        man_vld = 2'b11;
        sub_rdy = 1'b1;
        #1;
        check("post_rst_gnt", bus2.man_rdy, 2'b01);
        #1;
        run_cycle();

        repeat (200) drive(N'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6));
        repeat (3) drive(2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
